// File: rtl/mult_arbiter.sv
// mult_arbiter: two-requester round-robin front end for a shared 4x4
// unsigned array multiplier.
//
// A request is accepted in IDLE, multiplied in CALC (one cycle) and held
// as a response in RESP until the consumer takes it. Only one request is
// ever in flight.
//
// Ports
//   clk                    rising-edge clock for all state
//   rst_n                  asynchronous active-low reset
//   req0_valid/req1_valid  requester holds operands valid
//   req0_m/req1_m [3:0]    multiplicand
//   req0_q/req1_q [3:0]    multiplier
//   req0_ready/req1_ready  operands accepted this cycle (combinational)
//   rsp_valid              product held on rsp_p (registered)
//   rsp_id                 requester that owns rsp_p
//   rsp_p [7:0]            full unsigned product m*q
//   rsp_ready              consumer accepts the response
//   busy                   high whenever the FSM is not in IDLE

// array_mult_structural: 4x4 unsigned carry-save-free ripple array
// multiplier built from AND partial products and full-adder rows.
// Ports: m [3:0] multiplicand, q [3:0] multiplier, p [7:0] product.
module array_mult_structural (
  input  logic [3:0] m,
  input  logic [3:0] q,
  output logic [7:0] p
);

  // One full adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  logic [4:0] acc_s;
  logic [3:0] row_sum_s;
  logic       carry_s;
  logic [1:0] fa_s;

  // Ripple the array row by row; acc_s holds the running sum aligned so
  // that its bit 0 is the next finished product bit.
  always_comb begin
    acc_s     = {1'b0, m & {4{q[0]}}};
    row_sum_s = 4'h0;
    carry_s   = 1'b0;
    fa_s      = 2'b00;
    p         = 8'h00;
    p[0]      = acc_s[0];
    for (int i = 1; i < 4; i++) begin
      carry_s = 1'b0;
      for (int j = 0; j < 4; j++) begin
        fa_s         = full_add(m[j] & q[i], acc_s[j+1], carry_s);
        row_sum_s[j] = fa_s[0];
        carry_s      = fa_s[1];
      end
      acc_s = {carry_s, row_sum_s};
      p[i]  = acc_s[0];
    end
    p[7:4] = acc_s[4:1];
  end

endmodule

// mult_arbiter_checker: protocol properties of the request side.
// Ports: clk, rst_n, in_idle (FSM in IDLE), request valids and readys.
module mult_arbiter_checker (
  input logic clk,
  input logic rst_n,
  input logic in_idle,
  input logic req0_valid,
  input logic req1_valid,
  input logic req0_ready,
  input logic req1_ready
);

  a_ready0_legal: assert property (@(posedge clk) disable iff (!rst_n)
    req0_ready |-> (in_idle && req0_valid));

  a_ready1_legal: assert property (@(posedge clk) disable iff (!rst_n)
    req1_ready |-> (in_idle && req1_valid));

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

endmodule

module mult_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_m,
  input  logic [3:0] req0_q,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_m,
  input  logic [3:0] req1_q,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_p,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] op_m;
  logic [3:0] op_q;
  logic       id;
  logic       last;
  logic       grant_valid_s;
  logic       grant_id_s;
  logic [7:0] prod_s;

  array_mult_structural u_mult (
    .m (op_m),
    .q (op_q),
    .p (prod_s)
  );

  // Round-robin grant: a lone requester always wins; under contention the
  // requester that was not served last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = ~last;
      end else if (req0_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end else if (req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign req0_ready = grant_valid_s & ~grant_id_s;
  assign req1_ready = grant_valid_s &  grant_id_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; rsp_ready only matters in RESP.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: state_next_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Operand capture, response registers, round-robin pointer and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_m      <= 4'h0;
      op_q      <= 4'h0;
      id        <= 1'b0;
      last      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_p     <= 8'h00;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            op_m <= grant_id_s ? req1_m : req0_m;
            op_q <= grant_id_s ? req1_q : req0_q;
            id   <= grant_id_s;
            busy <= 1'b1;
          end
        end
        ST_CALC: begin
          rsp_p     <= prod_s;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last      <= id;
            busy      <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

  mult_arbiter_checker u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_idle    (state_r == ST_IDLE),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready)
  );

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed stimulus for mult_arbiter with a
// transaction-level reference model checked on every falling edge, plus
// hand-computed literal expectations for each scenario.
module tb_mult_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_m, req0_q, req1_m, req1_q;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_ready, busy;
  logic [7:0] rsp_p;

  int n_checks = 0;
  int n_errors = 0;

  mult_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_m     (req0_m),
    .req0_q     (req0_q),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_m     (req1_m),
    .req1_q     (req1_q),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_p      (rsp_p),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%02h required=0x%02h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // m_t: -1 idle, 0 computing, >=1 response outstanding
  int         m_t      = -1;
  logic [7:0] m_pend_p = 8'h00;
  logic [7:0] m_exp_p  = 8'h00;
  logic       m_pend_id = 1'b0;
  logic       m_exp_id  = 1'b0;
  logic       m_last    = 1'b1;

  function automatic logic pick(input logic v0, input logic v1, input logic lst);
    if (v0 && v1) return ~lst;
    return v1;
  endfunction

  function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
    int r;
    r = int'(a) * int'(b);
    return r[7:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t       <= -1;
      m_pend_p  <= 8'h00;
      m_exp_p   <= 8'h00;
      m_pend_id <= 1'b0;
      m_exp_id  <= 1'b0;
      m_last    <= 1'b1;
    end else if (m_t < 0) begin
      if (req0_valid || req1_valid) begin
        m_t       <= 0;
        m_pend_id <= pick(req0_valid, req1_valid, m_last);
        m_pend_p  <= pick(req0_valid, req1_valid, m_last) ? prod(req1_m, req1_q)
                                                           : prod(req0_m, req0_q);
      end
    end else if (m_t == 0) begin
      m_t      <= 1;
      m_exp_p  <= m_pend_p;
      m_exp_id <= m_pend_id;
    end else if (rsp_ready) begin
      m_t    <= -1;
      m_last <= m_exp_id;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    logic g, e0, e1;
    g  = pick(req0_valid, req1_valid, m_last);
    e0 = (m_t < 0) && req0_valid && !g;
    e1 = (m_t < 0) && req1_valid && g;
    chk("req0_ready", {7'h00, req0_ready}, {7'h00, e0});
    chk("req1_ready", {7'h00, req1_ready}, {7'h00, e1});
    chk("ready_excl", {7'h00, req0_ready & req1_ready}, 8'h00);
    chk("rsp_valid", {7'h00, rsp_valid}, {7'h00, m_t >= 1});
    chk("rsp_p", rsp_p, m_exp_p);
    chk("rsp_id", {7'h00, rsp_id}, {7'h00, m_exp_id});
    chk("busy", {7'h00, busy}, {7'h00, m_t >= 0});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 10; k++) begin
      if (!busy) break;
      step();
    end
    chk(name, {7'h00, busy}, 8'h00);
  endtask

  // Single directed request from an idle arbiter with rsp_ready high.
  task automatic do_req(input logic rid, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_p, input string name);
    rsp_ready = 1'b1;
    if (rid) begin
      req1_valid = 1'b1; req1_m = a; req1_q = b;
    end else begin
      req0_valid = 1'b1; req0_m = a; req0_q = b;
    end
    #1;
    chk({name, "_ready"}, {7'h00, rid ? req1_ready : req0_ready}, 8'h01);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk({name, "_valid"}, {7'h00, rsp_valid}, 8'h01);
    chk({name, "_p"}, rsp_p, exp_p);
    chk({name, "_id"}, {7'h00, rsp_id}, {7'h00, rid});
    step();
  endtask

  logic [8:0] got [3];
  int         n_got;

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_m = 4'h0; req0_q = 4'h0; req1_m = 4'h0; req1_q = 4'h0;
    rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("lit_rst_valid", {7'h00, rsp_valid}, 8'h00);
    chk("lit_rst_p", rsp_p, 8'h00);
    chk("lit_rst_id", {7'h00, rsp_id}, 8'h00);
    chk("lit_rst_busy", {7'h00, busy}, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request: 3*3, stimulus at edge N
    step();
    req0_valid = 1'b1; req0_m = 4'd3; req0_q = 4'd3; rsp_ready = 1'b1;
    #1;
    chk("lit_single_ready0", {7'h00, req0_ready}, 8'h01);
    step();                          // N+1: handshake
    req0_valid = 1'b0;
    chk("lit_single_busy", {7'h00, busy}, 8'h01);
    chk("lit_single_calc_valid", {7'h00, rsp_valid}, 8'h00);
    step();                          // N+2
    chk("lit_single_valid", {7'h00, rsp_valid}, 8'h01);
    chk("lit_single_p", rsp_p, 8'h09);
    chk("lit_single_id", {7'h00, rsp_id}, 8'h00);
    step();                          // N+3
    chk("lit_single_idle", {7'h00, busy}, 8'h00);
    chk("lit_single_done", {7'h00, rsp_valid}, 8'h00);

    // Contention: both valid from reset
    req0_valid = 1'b1; req0_m = 4'd2; req0_q = 4'd2;
    req1_valid = 1'b1; req1_m = 4'd8; req1_q = 4'd8;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) got[k] = 9'h1FF;
    n_got = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (rsp_valid && n_got < 3) begin
        got[n_got] = {rsp_id, rsp_p};
        n_got++;
      end
      if (n_got == 3) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("lit_cont_count", 8'(n_got), 8'd3);
    chk("lit_cont_r0", got[0][7:0], 8'h04);
    chk("lit_cont_r0_id", {7'h00, got[0][8]}, 8'h00);
    chk("lit_cont_r1", got[1][7:0], 8'h40);
    chk("lit_cont_r1_id", {7'h00, got[1][8]}, 8'h01);
    chk("lit_cont_r2", got[2][7:0], 8'h04);
    chk("lit_cont_r2_id", {7'h00, got[2][8]}, 8'h00);
    wait_idle("cont_drain_timeout");

    // Backpressure: 15*15 held for 5 cycles
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_m = 4'd15; req1_q = 4'd15;
    step();                          // handshake
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_m = 4'd1; req0_q = 4'd2;
    step();                          // into RESP
    for (int k = 0; k < 5; k++) begin
      chk("lit_bp_valid", {7'h00, rsp_valid}, 8'h01);
      chk("lit_bp_p", rsp_p, 8'hE1);
      chk("lit_bp_id", {7'h00, rsp_id}, 8'h01);
      chk("lit_bp_ready0", {7'h00, req0_ready}, 8'h00);
      chk("lit_bp_ready1", {7'h00, req1_ready}, 8'h00);
      step();
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("lit_bp_idle", {7'h00, busy}, 8'h00);
    chk("lit_bp_done", {7'h00, rsp_valid}, 8'h00);

    // Reset during CALC
    req0_valid = 1'b1; req0_m = 4'd5; req0_q = 4'd5;
    step();                          // handshake -> CALC
    req0_valid = 1'b0;
    chk("lit_rstop_calc_busy", {7'h00, busy}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rstop_valid", {7'h00, rsp_valid}, 8'h00);
    chk("lit_rstop_p", rsp_p, 8'h00);
    chk("lit_rstop_busy", {7'h00, busy}, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("lit_rstop_no_rsp", {7'h00, rsp_valid}, 8'h00);
    end

    // Zero and identity
    do_req(1'b0, 4'd0, 4'd15, 8'h00, "lit_zero");
    do_req(1'b1, 4'd1, 4'd1, 8'h01, "lit_ident");

    // rsp_ready pulsed during CALC is ignored
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_m = 4'd3; req1_q = 4'd5;
    step();                          // handshake -> CALC
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();                          // CALC -> RESP
    rsp_ready = 1'b0;
    chk("lit_proto_valid", {7'h00, rsp_valid}, 8'h01);
    chk("lit_proto_p", rsp_p, 8'h0F);
    step();
    chk("lit_proto_hold", {7'h00, rsp_valid}, 8'h01);
    rsp_ready = 1'b1;
    step();
    chk("lit_proto_idle", {7'h00, busy}, 8'h00);

    step();
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
